// File: rtl/pixel_buffer_pkg.sv
// rtl/pixel_buffer_pkg.sv - shared constants, pixel types and address helper for pixel_buffer
package pixel_buffer_pkg;

  localparam int WIDTH_DEF  = 160;
  localparam int HEIGHT_DEF = 120;
  localparam int CBITS_DEF  = 3;
  localparam int ADDR_W     = $clog2(WIDTH_DEF * HEIGHT_DEF);

  typedef logic [CBITS_DEF-1:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    color_t     color;
  } pixel_wr_t;

  // Row-major linear address; ADDR_W holds 127*160+255, so no input can wrap.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH_DEF) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// rtl/pixel_ram.sv - simple dual-port frame RAM, read-first, one-cycle registered read
module pixel_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // rdata only moves on re so the scanner can park a prefetched pixel here.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[ra];
  end

endmodule

// File: rtl/pixel_buffer.sv
// rtl/pixel_buffer.sv - DESim VGA plot sink: frame memory, clear sweep and raster scan-out
module pixel_buffer
  import pixel_buffer_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter int               HEIGHT   = HEIGHT_DEF,
  parameter int               CBITS    = CBITS_DEF,
  parameter logic [CBITS-1:0] BG_COLOR = '0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       VGA_X,
  input  logic [6:0]       VGA_Y,
  input  logic [CBITS-1:0] VGA_COLOR,
  input  logic             plot,
  input  logic             clear,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_x,
  output logic [6:0]       rd_y,
  output logic [CBITS-1:0] rd_color,
  output logic             rd_sof,
  output logic             rd_eol,
  output logic             busy,
  output logic             oob
);

  localparam int                NPIX      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [7:0]        X_LIM     = 8'(WIDTH);
  localparam logic [6:0]        Y_LIM     = 7'(HEIGHT);
  localparam logic [7:0]        X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]        Y_LAST    = 7'(HEIGHT - 1);
  localparam logic [0:0]        S_IDLE    = 1'b0;
  localparam logic [0:0]        S_CLEAR   = 1'b1;

  logic              plot_meta, plot_sync, plot_prev;
  logic              plot_rise, in_range, plot_req;
  pixel_wr_t         new_wr;
  logic [0:0]        state;
  logic              clear_prev, sweeping;
  logic [ADDR_W-1:0] clr_addr;
  logic              pend_valid;
  pixel_wr_t         pend;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CBITS-1:0]  wr_data;
  logic [7:0]        sx, s1_x;
  logic [6:0]        sy, s1_y;
  logic              s1_valid, out_load, issue;
  logic [CBITS-1:0]  ram_rdata;

  // plot can come straight from a pushbutton, hence the two-flop synchroniser.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      plot_meta <= 1'b0;
      plot_sync <= 1'b0;
      plot_prev <= 1'b0;
    end else begin
      plot_meta <= plot;
      plot_sync <= plot_meta;
      plot_prev <= plot_sync;
    end
  end

  assign plot_rise = plot_sync & ~plot_prev;
  assign in_range  = (VGA_X < X_LIM) && (VGA_Y < Y_LIM);
  assign plot_req  = plot_rise && in_range;

  always_comb begin
    new_wr       = '0;
    new_wr.x     = VGA_X;
    new_wr.y     = VGA_Y;
    new_wr.color = VGA_COLOR;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      clear_prev <= 1'b0;
      clr_addr   <= '0;
    end else begin
      clear_prev <= clear;
      case (state)
        S_IDLE: begin
          if (clear && !clear_prev) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          if (clr_addr == LAST_ADDR) state <= S_IDLE;
          clr_addr <= clr_addr + ADDR_W'(1);
        end
      endcase
    end
  end

  assign sweeping = (state == S_CLEAR);
  assign busy     = sweeping;

  // A plot that cannot use the write port parks here; a later plot replaces it.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (plot_req && (sweeping || pend_valid)) begin
      pend_valid <= 1'b1;
      pend       <= new_wr;
    end else if (!sweeping) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) oob <= 1'b0;
    else if (plot_rise && !in_range) oob <= 1'b1;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (sweeping) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = BG_COLOR;
    end else if (pend_valid) begin
      wr_en   = 1'b1;
      wr_addr = xy_to_addr(pend.x, pend.y);
      wr_data = pend.color;
    end else if (plot_req) begin
      wr_en   = 1'b1;
      wr_addr = xy_to_addr(VGA_X, VGA_Y);
      wr_data = VGA_COLOR;
    end
  end

  pixel_ram #(
    .DEPTH(NPIX),
    .AW   (ADDR_W),
    .DW   (CBITS)
  ) u_ram (
    .clk  (CLOCK_50),
    .we   (wr_en),
    .wa   (wr_addr),
    .wd   (wr_data),
    .re   (issue),
    .ra   (xy_to_addr(sx, sy)),
    .rdata(ram_rdata)
  );

  // s1 tags the pixel sitting in ram_rdata; a new read is issued only once s1 is free.
  assign out_load = !rd_valid || rd_ready;
  assign issue    = !s1_valid || out_load;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sx       <= '0;
      sy       <= '0;
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_color <= '0;
      rd_sof   <= 1'b0;
      rd_eol   <= 1'b0;
    end else begin
      if (issue) begin
        s1_valid <= 1'b1;
        s1_x     <= sx;
        s1_y     <= sy;
        if (sx == X_LAST) begin
          sx <= '0;
          sy <= (sy == Y_LAST) ? '0 : sy + 7'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end
      if (out_load) begin
        rd_valid <= s1_valid;
        if (s1_valid) begin
          rd_x     <= s1_x;
          rd_y     <= s1_y;
          rd_color <= ram_rdata;
          rd_sof   <= (s1_x == 8'd0) && (s1_y == 7'd0);
          rd_eol   <= (s1_x == X_LAST);
        end
      end
    end
  end

endmodule
